// File: rtl/axi_lite_register_slave.sv
// AXI-lite subordinate holding NUM_REGS byte-strobed read/write registers.
// Write and read channels run independent FSMs; every output is registered.
module axi_lite_register_slave #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LSB        = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = ADDR_WIDTH - LSB;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic                  aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c, commit_c;
  logic                  aw_done_q, w_done_q, aw_done_n, w_done_n;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_c, ar_idx_c;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_c, rd_word_c;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_c;
  logic                  aw_in_range_c, ar_in_range_c;
  logic                  awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
  logic [1:0]            bresp_n, rresp_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic                  unused_c;

  assign unused_c = ^{awprot, arprot, awaddr, araddr};

  assign aw_hs_c = awvalid & awready;
  assign w_hs_c  = wvalid & wready;
  assign b_hs_c  = bvalid & bready;
  assign ar_hs_c = arvalid & arready;
  assign r_hs_c  = rvalid & rready;

  // Use the latched beat if already captured, else the one handshaking now
  assign aw_idx_c = aw_done_q ? aw_idx_q : awaddr[ADDR_WIDTH-1:LSB];
  assign wdata_c  = w_done_q  ? wdata_q  : wdata;
  assign wstrb_c  = w_done_q  ? wstrb_q  : wstrb;
  assign ar_idx_c = araddr[ADDR_WIDTH-1:LSB];

  assign aw_in_range_c = {1'b0, aw_idx_c} < (IDX_W+1)'(NUM_REGS);
  assign ar_in_range_c = {1'b0, ar_idx_c} < (IDX_W+1)'(NUM_REGS);

  assign commit_c = (w_state == W_IDLE) & (aw_done_q | aw_hs_c) & (w_done_q | w_hs_c);

  // Pre-write register contents; out-of-range indices fall through to zero
  always_comb begin
    rd_word_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (ar_idx_c == IDX_W'(i)) rd_word_c = regs[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_n;
      r_state <= r_state_n;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_n = w_state;
    r_state_n = r_state;
    case (w_state)
      W_IDLE:  if (commit_c) w_state_n = W_RESP;
      W_RESP:  if (b_hs_c)   w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs_c) r_state_n = R_DATA;
      R_DATA:  if (r_hs_c)  r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Next values of the registered handshake and response outputs
  always_comb begin
    awready_n = awready;
    wready_n  = wready;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    aw_done_n = aw_done_q;
    w_done_n  = w_done_q;
    arready_n = arready;
    rvalid_n  = rvalid;
    rdata_n   = rdata;
    rresp_n   = rresp;
    if (w_state == W_IDLE) begin
      if (aw_hs_c) begin
        aw_done_n = 1'b1;
        awready_n = 1'b0;
      end
      if (w_hs_c) begin
        w_done_n = 1'b1;
        wready_n = 1'b0;
      end
      if (commit_c) begin
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        bvalid_n  = 1'b1;
        bresp_n   = aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (b_hs_c) begin
      bvalid_n  = 1'b0;
      awready_n = 1'b1;
      wready_n  = 1'b1;
    end
    if (r_state == R_IDLE) begin
      if (ar_hs_c) begin
        arready_n = 1'b0;
        rvalid_n  = 1'b1;
        rdata_n   = rd_word_c;
        rresp_n   = ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (r_hs_c) begin
      rvalid_n  = 1'b0;
      arready_n = 1'b1;
    end
  end

  // Output, capture and register-file flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      awready   <= 1'b1;
      wready    <= 1'b1;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      regs      <= '0;
    end else begin
      awready   <= awready_n;
      wready    <= wready_n;
      bvalid    <= bvalid_n;
      bresp     <= bresp_n;
      aw_done_q <= aw_done_n;
      w_done_q  <= w_done_n;
      arready   <= arready_n;
      rvalid    <= rvalid_n;
      rdata     <= rdata_n;
      rresp     <= rresp_n;
      if (aw_hs_c) aw_idx_q <= awaddr[ADDR_WIDTH-1:LSB];
      if (w_hs_c) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit_c && aw_in_range_c) begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
          if (aw_idx_c == IDX_W'(i)) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
              if (wstrb_c[b]) regs[i*DATA_WIDTH + b*8 +: 8] <= wdata_c[b*8 +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_register_slave.sv
// Scoreboard bench for axi_lite_register_slave: stimulus queues expected B/R
// responses, a negedge monitor pops and compares on each response handshake.
module tb_axi_lite_register_slave;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] regs;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0]  b_exp[$];
  rexp_t       r_exp[$];
  logic [31:0] mreg[16];
  int          errors = 0;
  int          checks = 0;

  axi_lite_register_slave dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs(regs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s reg%0d", nm, i), regs[i*32 +: 32], mreg[i]);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (reset && bvalid && bready) begin
      checks++;
      if (b_exp.size() == 0) begin
        errors++;
        $display("FAIL bresp unexpected: got %b with nothing expected", bresp);
      end else begin
        logic [1:0] e;
        e = b_exp.pop_front();
        if (bresp !== e) begin
          errors++;
          $display("FAIL bresp: got %b expected %b", bresp, e);
        end
      end
    end
    if (reset && rvalid && rready) begin
      checks++;
      if (r_exp.size() == 0) begin
        errors++;
        $display("FAIL rdata unexpected: got %h/%b with nothing expected", rdata, rresp);
      end else begin
        rexp_t e;
        e = r_exp.pop_front();
        if (rdata !== e.d || rresp !== e.r) begin
          errors++;
          $display("FAIL rdata/rresp: got %h/%b expected %h/%b", rdata, rresp, e.d, e.r);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((b_exp.size() != 0 || r_exp.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: b pending %0d r pending %0d expected 0", b_exp.size(), r_exp.size());
      b_exp.delete();
      r_exp.delete();
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
    int n = 0;
    logic ah, wh;
    b_exp.push_back(er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(posedge clk); #1;
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL write accept timeout: addr %h not accepted", a);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    drain();
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n = 0;
    logic hit;
    r_exp.push_back('{d: ed, r: er});
    araddr = a; arvalid = 1'b1;
    while (arvalid && n < 20) begin
      hit = arready;
      @(posedge clk); #1;
      if (hit) arvalid = 1'b0;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL read accept timeout: addr %h not accepted", a);
      arvalid = 1'b0;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: bench still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_v;
    reset = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst awready", 32'(awready), 32'd1);
    chk("rst wready",  32'(wready),  32'd1);
    chk("rst arready", 32'(arready), 32'd1);
    chk("rst bvalid",  32'(bvalid),  32'd0);
    chk("rst rvalid",  32'(rvalid),  32'd0);
    chk_regs("rst");

    // AW+W same cycle: bvalid right after the commit edge
    b_exp.push_back(2'b00);
    awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("lat bvalid", 32'(bvalid), 32'd1);
    chk("lat awready", 32'(awready), 32'd0);
    chk("lat wready", 32'(wready), 32'd0);
    chk("lat reg1", regs[32 +: 32], 32'hDEADBEEF);
    drain();
    mreg[1] = 32'hDEADBEEF;
    chk_regs("w1");
    do_read(8'h04, 32'hDEADBEEF, 2'b00);

    // W first, AW three cycles later
    b_exp.push_back(2'b00);
    wdata = 32'h000000AA; wstrb = 4'b0001; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("wfirst wready", 32'(wready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("wfirst bvalid early", 32'(bvalid), 32'd0);
    chk("wfirst reg1 early", regs[32 +: 32], 32'hDEADBEEF);
    awaddr = 8'h04; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("wfirst bvalid", 32'(bvalid), 32'd1);
    drain();
    mreg[1] = 32'hDEADBEAA;
    chk_regs("wfirst");

    // Zero strobe, unaligned read, partial strobes
    do_write(8'h04, 32'hFFFFFFFF, 4'h0, 2'b00);
    chk_regs("strb0");
    do_read(8'h07, 32'hDEADBEAA, 2'b00);
    do_write(8'h0C, 32'hAABBCCDD, 4'b1010, 2'b00);
    mreg[3] = 32'hAA00CC00;
    do_read(8'h0C, 32'hAA00CC00, 2'b00);

    // Out-of-range decode
    do_write(8'h40, 32'h12345678, 4'hF, 2'b10);
    chk_regs("oor");
    do_read(8'h40, 32'h0, 2'b10);
    do_read(8'hFC, 32'h0, 2'b10);

    // Same-edge read and write of one register returns the old value
    do_write(8'h08, 32'h11223344, 4'hF, 2'b00);
    b_exp.push_back(2'b00);
    r_exp.push_back('{d: 32'h11223344, r: 2'b00});
    awaddr = 8'h08; wdata = 32'h55667788; wstrb = 4'hF; araddr = 8'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    drain();
    mreg[2] = 32'h55667788;
    chk_regs("rw");
    do_read(8'h08, 32'h55667788, 2'b00);

    // Back-pressure on B and R
    bready = 1'b0;
    b_exp.push_back(2'b10);
    awaddr = 8'h80; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bhold bvalid", 32'(bvalid), 32'd1);
      chk("bhold bresp", 32'(bresp), 32'd2);
      chk("bhold awready", 32'(awready), 32'd0);
      chk("bhold wready", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    drain();

    rready = 1'b0;
    r_exp.push_back('{d: 32'hDEADBEAA, r: 2'b00});
    araddr = 8'h04; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      hold_v = rdata;
      chk("rhold rvalid", 32'(rvalid), 32'd1);
      chk("rhold rdata", hold_v, 32'hDEADBEAA);
      chk("rhold rresp", 32'(rresp), 32'd0);
      chk("rhold arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    drain();

    // Reset asserted while a write response is pending
    bready = 1'b0;
    b_exp.push_back(2'b00);
    awaddr = 8'h10; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("mid bvalid", 32'(bvalid), 32'd1);
    reset = 1'b0;
    #1;
    b_exp.delete();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    chk("mid rst bvalid", 32'(bvalid), 32'd0);
    chk_regs("mid rst");
    @(posedge clk); #1;
    reset = 1'b1;
    bready = 1'b1;
    @(posedge clk); #1;
    chk("post awready", 32'(awready), 32'd1);
    chk("post wready", 32'(wready), 32'd1);
    chk("post arready", 32'(arready), 32'd1);
    chk("post bvalid", 32'(bvalid), 32'd0);
    do_write(8'h00, 32'h01020304, 4'hF, 2'b00);
    mreg[0] = 32'h01020304;
    do_read(8'h00, 32'h01020304, 2'b00);
    chk_regs("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
